fifo_sync_flags: RTL

//  Parametrised synchronous FIFO; next generation of the team's basic push/pop FIFO.

---
 rtl/fifo_sync_flags_if.sv | 32 +++
 rtl/fifo_sync_flags.sv | 112 +++++++++++
 2 files changed

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer-facing signal bundle for fifo_sync_flags.
// The master side drives requests and write data; the slave (the FIFO) drives data and status.
interface fifo_sync_flags_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_vld;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    modport master (
        output data_in, push, pop, err_clr,
        input  data_out, data_vld, full, empty, almost_full, almost_empty, count, ovf, udf
    );

    modport slave (
        input  data_in, push, pop, err_clr,
        output data_out, data_vld, full, empty, almost_full, almost_empty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with full/empty/almost flags, live fill count, sticky overflow/underflow
// and a choice of show-ahead or registered read data.
module fifo_sync_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int OUT_REG   = 0
) (
    input logic              clk,
    input logic              FIFO_reset,
    fifo_sync_flags_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             udf_q;
    logic             full;
    logic             empty;
    logic             wpush;
    logic             wpop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
    assign wpush = bus.push & (~full | bus.pop);
    assign wpop  = bus.pop & ~empty;

    // Explicit wrap so that non-power-of-2 depths cycle through exactly DEPTH slots.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // NOTE: storage carries no reset; contents are meaningless until written, and a resettable array costs a mux per bit.
    always_ff @(posedge clk) begin
        if (!FIFO_reset && wpush)
            mem[wr_ptr] <= bus.data_in;
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values, so block order cannot change behaviour.
    always_ff @(posedge clk) begin
        if (FIFO_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wpush) wr_ptr <= next_ptr(wr_ptr);
            if (wpop)  rd_ptr <= next_ptr(rd_ptr);
            case ({wpush, wpop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A fresh error outranks err_clr so a same-cycle event is never lost.
    always_ff @(posedge clk) begin
        if (FIFO_reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.push && full && !bus.pop) ovf_q <= 1'b1;
            else if (bus.err_clr)             ovf_q <= 1'b0;
            if (bus.pop && empty)             udf_q <= 1'b1;
            else if (bus.err_clr)             udf_q <= 1'b0;
        end
    end

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.ovf          = ovf_q;
    assign bus.udf          = udf_q;

    generate
        if (OUT_REG == 0) begin : g_show_ahead
            // NOTE: assigning a default first in always_comb guarantees no path leaves the output unassigned, so no latch.
            always_comb begin
                bus.data_out = '0;
                if (!empty)
                    bus.data_out = mem[rd_ptr];
            end
            assign bus.data_vld = ~empty;
        end else begin : g_registered
            logic [WIDTH-1:0] dout_q;
            logic             vld_q;

            always_ff @(posedge clk) begin
                if (FIFO_reset) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    vld_q <= wpop;
                    if (wpop)
                        dout_q <= mem[rd_ptr];
                end
            end

            assign bus.data_out = dout_q;
            assign bus.data_vld = vld_q;
        end
    endgenerate
endmodule
